// File: rtl/mem_stage.sv
// Memory-access stage: captures the EX bundle, runs a req/ack access to data memory
// and presents a registered one-cycle writeback bundle, including the ret/call side-band.
module mem_stage #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             RegWrite_in,
    input  logic             MemWrite_in,
    input  logic             MemRead_in,
    input  logic             mem_to_reg_in,
    input  logic             ret_future_in,
    input  logic             call_in,
    input  logic [3:0]       reg_rd_in,
    input  logic [DW-1:0]    alu_result,
    input  logic [DW-1:0]    sw_data,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [DW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    input  logic             mem_ack,
    output logic             wb_valid,
    output logic             wb_reg_write,
    output logic [3:0]       wb_reg_rd,
    output logic [DW-1:0]    wb_data,
    output logic             ret_wb,
    output logic [DW-1:0]    ret_pc,
    output logic             call_wb,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state;

    logic          h_rw, h_mw, h_m2r, h_ret, h_call;
    logic [3:0]    h_rd;
    logic [DW-1:0] h_addr, h_wdata;

    logic          s_valid, s_rw, s_ret, s_call;
    logic [3:0]    s_rd;
    logic [DW-1:0] s_data;

    logic          in_wait, mem_done, accept, new_mem;
    logic [DW-1:0] mem_result;

    logic          ret_en, r_rw, r_ret, r_call;
    logic [3:0]    r_rd;
    logic [DW-1:0] r_data;

    assign in_wait  = (state == S_WAIT);
    assign mem_done = in_wait & mem_ack;
    // The skid cycle also stalls so the bundle behind it cannot overtake it.
    assign stall    = (in_wait & ~mem_ack) | s_valid;
    assign accept   = ex_valid & ~stall;
    assign new_mem  = MemRead_in | MemWrite_in;

    assign mem_req   = in_wait;
    assign mem_we    = in_wait & h_mw;
    assign mem_addr  = in_wait ? h_addr  : '0;
    assign mem_wdata = in_wait ? h_wdata : '0;

    // A write wins over a read, so a write never returns memory data.
    assign mem_result = (h_m2r & ~h_mw) ? mem_rdata : h_addr;
    assign ret_pc     = wb_data;

    always_comb begin
        ret_en = 1'b0;
        r_rw   = 1'b0;
        r_ret  = 1'b0;
        r_call = 1'b0;
        r_rd   = '0;
        r_data = '0;
        if (s_valid) begin
            ret_en = 1'b1;
            r_rw   = s_rw;
            r_ret  = s_ret;
            r_call = s_call;
            r_rd   = s_rd;
            r_data = s_data;
        end else if (mem_done) begin
            ret_en = 1'b1;
            r_rw   = h_rw;
            r_ret  = h_ret;
            r_call = h_call;
            r_rd   = h_rd;
            r_data = mem_result;
        end else if (accept && !new_mem && !in_wait) begin
            ret_en = 1'b1;
            r_rw   = RegWrite_in;
            r_ret  = ret_future_in;
            r_call = call_in;
            r_rd   = reg_rd_in;
            r_data = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            h_rw         <= 1'b0;
            h_mw         <= 1'b0;
            h_m2r        <= 1'b0;
            h_ret        <= 1'b0;
            h_call       <= 1'b0;
            h_rd         <= '0;
            h_addr       <= '0;
            h_wdata      <= '0;
            s_valid      <= 1'b0;
            s_rw         <= 1'b0;
            s_ret        <= 1'b0;
            s_call       <= 1'b0;
            s_rd         <= '0;
            s_data       <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg_rd    <= '0;
            wb_data      <= '0;
            ret_wb       <= 1'b0;
            call_wb      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            wb_valid <= ret_en;
            ret_wb   <= ret_en & r_ret;
            call_wb  <= ret_en & r_call;
            if (ret_en) begin
                wb_reg_write <= r_rw;
                wb_reg_rd    <= r_rd;
                wb_data      <= r_data;
            end

            if (stall && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);

            s_valid <= mem_done & accept & ~new_mem;
            if (mem_done && accept && !new_mem) begin
                s_rw   <= RegWrite_in;
                s_ret  <= ret_future_in;
                s_call <= call_in;
                s_rd   <= reg_rd_in;
                s_data <= alu_result;
            end

            if (accept && new_mem) begin
                state   <= S_WAIT;
                h_rw    <= RegWrite_in;
                h_mw    <= MemWrite_in;
                h_m2r   <= mem_to_reg_in;
                h_ret   <= ret_future_in;
                h_call  <= call_in;
                h_rd    <= reg_rd_in;
                h_addr  <= alu_result;
                h_wdata <= sw_data;
            end else if (mem_done) begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic, checked against an
// ordered-retirement reference model of the stage.
module tb_mem_stage;

    localparam int DW    = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex_valid, RegWrite_in, MemWrite_in, MemRead_in, mem_to_reg_in;
    logic             ret_future_in, call_in;
    logic [3:0]       reg_rd_in;
    logic [DW-1:0]    alu_result, sw_data;
    logic             stall, mem_req, mem_we;
    logic [DW-1:0]    mem_addr, mem_wdata, mem_rdata;
    logic             mem_ack;
    logic             wb_valid, wb_reg_write;
    logic [3:0]       wb_reg_rd;
    logic [DW-1:0]    wb_data, ret_pc;
    logic             ret_wb, call_wb;
    logic [CNT_W-1:0] stall_cycles;

    mem_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid),
        .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .mem_to_reg_in(mem_to_reg_in), .ret_future_in(ret_future_in), .call_in(call_in),
        .reg_rd_in(reg_rd_in), .alu_result(alu_result), .sw_data(sw_data),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_reg_rd(wb_reg_rd),
        .wb_data(wb_data), .ret_wb(ret_wb), .ret_pc(ret_pc), .call_wb(call_wb),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, mw, mr, m2r, ret, call;
        logic [3:0]  rd;
        logic [15:0] alu, sw;
    } bundle_t;

    int checks = 0;
    int errors = 0;

    // Reference model: at most one outstanding memory op plus at most one queued bundle.
    bit          busy, skid_pend;
    bundle_t     busy_b, skid_b;
    logic [15:0] last_data;
    logic [3:0]  last_rd;
    logic        last_rw;
    int          exp_cnt;

    int          obs_req, obs_stall;
    logic        obs_we;
    logic [15:0] obs_wdata;

    bundle_t     nb;
    bundle_t     idle_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t mk(input logic rw, mw, mr, m2r, ret, call,
                                   input logic [3:0] rd, input logic [15:0] alu, sw);
        bundle_t b;
        b.rw = rw; b.mw = mw; b.mr = mr; b.m2r = m2r; b.ret = ret; b.call = call;
        b.rd = rd; b.alu = alu; b.sw = sw;
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ex_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        @(posedge clk); #1;
        busy = 0; skid_pend = 0; exp_cnt = 0;
        last_data = '0; last_rd = '0; last_rw = 1'b0;
        chk("rst_stall", stall, 0);         chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);       chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0); chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_reg_write", wb_reg_write, 0); chk("rst_wb_reg_rd", wb_reg_rd, 0);
        chk("rst_wb_data", wb_data, 0);     chk("rst_ret_wb", ret_wb, 0);
        chk("rst_ret_pc", ret_pc, 0);       chk("rst_call_wb", call_wb, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
    endtask

    // One clock: apply inputs, check combinational outputs, advance, check WB bundle.
    task automatic drive(input bit v, input bundle_t b, input bit ack, input logic [15:0] rdat);
        bit          exp_stall, accept, is_mem, retire;
        bundle_t     rb;
        logic [15:0] rdata_exp;
        @(negedge clk);
        rst = 1'b0;
        ex_valid = v; RegWrite_in = b.rw; MemWrite_in = b.mw; MemRead_in = b.mr;
        mem_to_reg_in = b.m2r; ret_future_in = b.ret; call_in = b.call;
        reg_rd_in = b.rd; alu_result = b.alu; sw_data = b.sw;
        mem_ack = ack; mem_rdata = rdat;
        #1;
        exp_stall = (busy && !ack) || skid_pend;
        chk("stall", stall, exp_stall);
        chk("mem_req", mem_req, busy);
        if (busy) begin
            chk("mem_we", mem_we, busy_b.mw);
            chk("mem_addr", mem_addr, busy_b.alu);
            chk("mem_wdata", mem_wdata, busy_b.sw);
        end
        obs_req += int'(mem_req); obs_stall += int'(stall);
        obs_we = mem_we; obs_wdata = mem_wdata;

        accept = v && !exp_stall;
        is_mem = b.mr || b.mw;
        retire = 0; rb = b; rdata_exp = b.alu;
        if (skid_pend) begin
            retire = 1; rb = skid_b; rdata_exp = skid_b.alu;
        end else if (busy && ack) begin
            retire = 1; rb = busy_b;
            rdata_exp = (!busy_b.mw && busy_b.m2r) ? rdat : busy_b.alu;
        end else if (accept && !is_mem) begin
            retire = 1; rb = b; rdata_exp = b.alu;
        end

        if (exp_stall && exp_cnt < 65535) exp_cnt++;
        if (skid_pend) skid_pend = 0;
        if (accept && is_mem) begin
            busy = 1; busy_b = b;
        end else begin
            if (accept && busy && ack) begin
                skid_pend = 1; skid_b = b;
            end
            if (busy && ack) busy = 0;
        end

        @(posedge clk); #1;
        chk("wb_valid", wb_valid, retire);
        if (retire) begin
            last_data = rdata_exp; last_rd = rb.rd; last_rw = rb.rw;
        end
        chk("wb_data", wb_data, last_data);
        chk("wb_reg_rd", wb_reg_rd, last_rd);
        chk("wb_reg_write", wb_reg_write, last_rw);
        chk("ret_wb", ret_wb, retire && rb.ret);
        chk("call_wb", call_wb, retire && rb.call);
        chk("ret_pc", ret_pc, last_data);
        chk("stall_cycles", stall_cycles, exp_cnt);
    endtask

    initial begin
        idle_b = mk(0, 0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
        rst = 1'b1; ex_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0; mem_to_reg_in = 0;
        ret_future_in = 0; call_in = 0; reg_rd_in = '0; alu_result = '0; sw_data = '0;
        obs_req = 0; obs_stall = 0;
        do_reset();

        // ALU op retires after one cycle, no memory request.
        obs_req = 0;
        drive(1, mk(1, 0, 0, 0, 0, 0, 4'd3, 16'h1234, 16'h0), 0, 16'h0);
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_data", wb_data, 16'h1234);
        chk("alu_wb_rd", wb_reg_rd, 3);
        drive(0, idle_b, 0, 16'h0);
        chk("alu_no_req", obs_req, 0);

        // Load acked on the third WAIT cycle.
        obs_req = 0; obs_stall = 0;
        drive(1, mk(1, 0, 1, 1, 0, 0, 4'd5, 16'h0040, 16'h0), 0, 16'h0);
        drive(0, idle_b, 0, 16'h0);
        drive(0, idle_b, 0, 16'h0);
        drive(0, idle_b, 1, 16'hBEEF);
        chk("ld_req_cycles", obs_req, 3);
        chk("ld_stall_cycles", obs_stall, 2);
        chk("ld_wb_data", wb_data, 16'hBEEF);
        chk("ld_cnt", stall_cycles, 2);

        // Store acked in its first WAIT cycle.
        drive(1, mk(0, 1, 0, 0, 0, 0, 4'd7, 16'h0010, 16'h5A5A), 0, 16'h0);
        chk("st_not_yet", wb_valid, 0);
        drive(0, idle_b, 1, 16'hFFFF);
        chk("st_we", obs_we, 1);
        chk("st_wdata", obs_wdata, 16'h5A5A);
        chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_rw", wb_reg_write, 0);
        chk("st_wb_data", wb_data, 16'h0010);

        // Ret pop and call push.
        drive(1, mk(1, 0, 1, 1, 1, 0, 4'd15, 16'h00FE, 16'h0), 0, 16'h0);
        drive(0, idle_b, 1, 16'h0123);
        chk("ret_wb_pulse", ret_wb, 1);
        chk("ret_pc_val", ret_pc, 16'h0123);
        drive(0, idle_b, 0, 16'h0);
        chk("ret_wb_drop", ret_wb, 0);
        drive(1, mk(0, 1, 0, 0, 0, 1, 4'd14, 16'h00FD, 16'h0456), 0, 16'h0);
        drive(0, idle_b, 1, 16'h0);
        chk("call_wb_pulse", call_wb, 1);

        // Load then ALU op offered in the ack cycle; EX holds its next bundle during the skid cycle.
        obs_stall = 0;
        drive(1, mk(1, 0, 1, 1, 0, 0, 4'd1, 16'h0080, 16'h0), 0, 16'h0);
        drive(0, idle_b, 0, 16'h0);
        drive(1, mk(1, 0, 0, 0, 0, 0, 4'd2, 16'h7777, 16'h0), 1, 16'hAAAA);
        chk("b2b_first", wb_data, 16'hAAAA);
        obs_stall = 0;
        nb = mk(1, 0, 0, 0, 0, 0, 4'd6, 16'h6666, 16'h0);
        drive(1, nb, 0, 16'h0);
        chk("b2b_skid_stall", obs_stall, 1);
        chk("b2b_second", wb_data, 16'h7777);
        chk("b2b_second_rd", wb_reg_rd, 2);
        drive(1, nb, 0, 16'h0);
        chk("b2b_third", wb_data, 16'h6666);

        // Reset while waiting, then stray acks.
        drive(1, mk(1, 0, 1, 1, 0, 0, 4'd9, 16'h0200, 16'h0), 0, 16'h0);
        drive(0, idle_b, 0, 16'h0);
        do_reset();
        repeat (3) drive(0, idle_b, 1, 16'hDEAD);
        chk("stray_no_wb", wb_valid, 0);

        // Long outstanding load drives the stall counter into saturation.
        drive(1, mk(1, 0, 1, 1, 0, 0, 4'd4, 16'h0300, 16'h0), 0, 16'h0);
        repeat (65537) drive(0, idle_b, 0, 16'h0);
        chk("sat_value", stall_cycles, 16'hFFFF);
        drive(0, idle_b, 1, 16'h4242);
        chk("sat_hold", stall_cycles, 16'hFFFF);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bundle_t rb;
            logic    w, r;
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) == 0);
            rb = mk(1'($urandom), w, r, 1'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), 16'($urandom), 16'($urandom));
            drive(($urandom_range(0, 9) < 7), rb, ($urandom_range(0, 9) < 4), 16'($urandom));
        end
        repeat (4) drive(0, idle_b, 1, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
